dbus_ram_responder: RTL and testbench
=====================================

# dbus_ram_responder

Single-port on-chip data RAM that answers the core's data-bus requests as the responding end of the Dbus wait-request protocol. It accepts byte, halfword and word reads and writes whose byte enables are right-justified (4'b0001, 4'b0011, 4'b1111), lane-shifts them by the low address bits, and returns load data right-justified in bits [7:0]/[15:0]/[31:0]. Reads hold `oWait` high for a configurable latency; writes complete with zero wait. The block sits directly on the core's Dbus ports with no interconnect in between.

## Interface
- `ADDR_W`, 10, word-address bits; RAM depth is 2^ADDR_W words of 32 bits.
- `READ_LAT`, 1, number of cycles `oWait` is high for a read; legal range 1..15.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `iAddr`  in  32  byte address; bits [ADDR_W+1:2] select the word, [1:0] the lane, the rest are ignored (aliasing).
- `iRead`  in  1  read request, held by the core until `oWait` samples low.
- `iWe`  in  1  write request.
- `iData`  in  32  store data, right-justified.
- `iByteEn`  in  4  right-justified size mask: 0001 byte, 0011 half, 1111 word; other values are a no-op.
- `oData`  out  32  read data, right-justified, zero-filled above the access size (the core sign/zero-extends).
- `oWait`  out  1  wait request; combinational.
- `oErr`  out  1  sticky misalignment flag (see Configuration).

## Operation
- Lane mask = (iByteEn << iAddr[1:0]) truncated to 4 bits; write data = iData << (8*iAddr[1:0]).
- FSM states: IDLE, RD_WAIT, RD_DONE.
- IDLE, `iWe`=1: write the masked lanes at the clock edge, `oWait`=0, stay in IDLE. Write has priority if `iRead` and `iWe` are both high; the read is ignored that cycle.
- IDLE, `iRead`=1, `iWe`=0: `oWait`=1 in the same cycle. Latch the word address and lane offset, load the counter with READ_LAT-1, go to RD_WAIT (READ_LAT=1 goes directly to RD_DONE and registers the data).
- RD_WAIT: `oWait`=1; decrement the counter. At zero, register oData = mem[word] >> (8*lane), masked to the access size, and go to RD_DONE.
- RD_DONE: `oWait`=0, `oData` valid. On the next edge go to IDLE unconditionally, because the core has consumed the data.
- A back-to-back read is first seen in IDLE on the following cycle and waits the full READ_LAT again.
- If `iRead` drops during RD_WAIT (core squash), the FSM still completes to RD_DONE; the data is discarded.
- `oData` holds its last value outside RD_DONE.
- Reset values: state IDLE, counter 0, `oData`=0, `oErr`=0. `oWait` is forced to 0 while `rst_n` is low. RAM contents are not reset.
- Reset asserted mid-read: the FSM goes to IDLE immediately. After release, a still-held `iRead` restarts a full read.

## Timing
- Read latency: request in cycle 0 with `oWait` high for cycles 0..READ_LAT-1; `oWait` low with valid `oData` in cycle READ_LAT, sampled by the core at the end of that cycle.
- Write: zero-wait, committed at the end of cycle 0. A read of the same word in cycle 1 returns the new data.
- Throughput: one read per READ_LAT+1 cycles; one write per cycle.
- `oWait` depends combinationally only on `state`, `iRead`, `iWe` and `rst_n`; no path from `iAddr` or `iData`.

## Configuration
- `DBUS_RAM_MISALIGN_CHK_EN` defined:
  - A halfword at offset 3 or a word at a nonzero offset is misaligned.
  - A misaligned write is suppressed.
  - A misaligned read completes with the normal latency and returns 0.
  - `oErr` is set at the request edge and stays set until reset.
- Not defined:
  - Lanes shifted past lane 3 are silently dropped.
  - A misaligned read returns the remaining upper lanes, right-justified and zero-filled.
  - `oErr` is tied to 0.

## Test plan
- Word write then read, READ_LAT=1: write 0xDEADBEEF at 0x40 -> read 0x40 shows `oWait`=1 for 1 cycle, then `oData`=0xDEADBEEF.
- Byte lanes: write 0xAA at 0x41 and 0xBBCC half at 0x42 over 0x11223344 -> word read 0xBBCCAA44; byte read 0x41 = 0x000000AA.
- READ_LAT=4: `oWait` high exactly 4 cycles; drop `iRead` in cycle 2 -> FSM returns to IDLE by cycle 5 and the next read is unaffected.
- Simultaneous `iRead`+`iWe` in IDLE -> `oWait`=0, write committed, FSM stays in IDLE.
- Reset pulse in RD_WAIT -> `oWait`=0 while reset is asserted, `oData`=0; after release with `iRead` held, a full READ_LAT wait occurs.
- With the macro defined: word write at 0x42 -> memory unchanged, `oErr`=1 and sticky. Without it: `oErr` stays 0 and only lanes 2..3 are written.

Source files
------------

// File: rtl/dbus_ram_responder_if.sv
// dbus_ram_responder_if: Dbus wait-request bus between the core (master) and the data RAM (slave).
interface dbus_ram_responder_if;
    logic [31:0] iAddr;
    logic        iRead;
    logic        iWe;
    logic [31:0] iData;
    logic [3:0]  iByteEn;
    logic [31:0] oData;
    logic        oWait;
    logic        oErr;
    modport master (output iAddr, iRead, iWe, iData, iByteEn, input oData, oWait, oErr);
    modport slave (input iAddr, iRead, iWe, iData, iByteEn, output oData, oWait, oErr);
endinterface

// File: rtl/dbus_ram_responder.sv
// dbus_ram_responder: single-port data RAM answering Dbus requests with wait-request reads and zero-wait writes.
// Define DBUS_RAM_MISALIGN_CHK_EN to suppress misaligned accesses and raise a sticky oErr.
module dbus_ram_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    dbus_ram_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [1:0]        lane_q, lane_d;
    logic [3:0]        be_q, be_d;
    logic              mis_q, mis_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] word, rd_word;
    logic [1:0]        lane, rd_lane;
    logic [3:0]        be_in, lane_mask, rd_be;
    logic              idle, be_ok, mis, wr_en, rd_mis, unused_addr;
    logic [31:0]       wr_data, rd_raw, rd_data;

    assign idle    = state_q == IDLE;
    assign word    = bus.iAddr[ADDR_W+1:2];
    assign lane    = bus.iAddr[1:0];
    assign be_ok   = bus.iByteEn inside {4'b0001, 4'b0011, 4'b1111};
    assign be_in   = be_ok ? bus.iByteEn : 4'b0;
`ifdef DBUS_RAM_MISALIGN_CHK_EN
    assign mis = (bus.iByteEn == 4'b0011 && lane == 2'd3) || (bus.iByteEn == 4'b1111 && lane != 2'd0);
`else
    assign mis = 1'b0;
`endif
    // Lanes shifted past lane 3 fall off the top of the 4-bit mask.
    assign lane_mask   = mis ? 4'b0 : be_in << lane;
    assign wr_data     = bus.iData << {lane, 3'b0};
    assign wr_en       = rst_n && idle && bus.iWe;
    assign unused_addr = ^bus.iAddr[31:ADDR_W+2];

    // In IDLE the read path looks at the live request so READ_LAT=1 can register data on the request edge.
    assign rd_word = idle ? word : word_q;
    assign rd_lane = idle ? lane : lane_q;
    assign rd_be   = idle ? be_in : be_q;
    assign rd_mis  = idle ? mis : mis_q;
    assign rd_raw  = mem[rd_word] >> {rd_lane, 3'b0};
    assign rd_data = rd_mis ? 32'b0 : rd_raw & {{8{rd_be[3]}}, {8{rd_be[2]}}, {8{rd_be[1]}}, {8{rd_be[0]}}};

    assign bus.oWait = rst_n && ((idle && bus.iRead && !bus.iWe) || state_q == RD_WAIT);
    assign bus.oData = data_q;
    assign bus.oErr  = err_q;

    always_ff @(posedge clk)
        for (int b = 0; b < 4; b++)
            if (wr_en && lane_mask[b]) mem[word][8*b +: 8] <= wr_data[8*b +: 8];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            lane_q  <= '0;
            be_q    <= '0;
            mis_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            be_q    <= be_d;
            mis_q   <= mis_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        lane_d  = lane_q;
        be_d    = be_q;
        mis_d   = mis_q;
        data_d  = data_q;
        err_d   = err_q | (idle && (bus.iWe || bus.iRead) && mis);
        unique case (state_q)
            IDLE: if (bus.iRead && !bus.iWe) begin
                word_d = word;
                lane_d = lane;
                be_d   = be_in;
                mis_d  = mis;
                cnt_d  = 4'(READ_LAT - 1);
                if (READ_LAT == 1) begin
                    data_d  = rd_data;
                    state_d = RD_DONE;
                end else state_d = RD_WAIT;
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    data_d  = rd_data;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dbus_ram_responder.sv
// tb_dbus_ram_responder: scoreboarded bench driving a READ_LAT=1 and a READ_LAT=4 responder.
module tb_dbus_ram_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    dbus_ram_responder_if b1();
    dbus_ram_responder_if b4();
    dbus_ram_responder #(.ADDR_W(10), .READ_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    dbus_ram_responder #(.ADDR_W(10), .READ_LAT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

`ifdef DBUS_RAM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    task automatic drive(input int s, input logic rd, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (s == 0) begin
            b1.iRead = rd; b1.iWe = we; b1.iAddr = a; b1.iData = d; b1.iByteEn = be;
        end else begin
            b4.iRead = rd; b4.iWe = we; b4.iAddr = a; b4.iData = d; b4.iByteEn = be;
        end
    endtask

    task automatic get(input int s, output logic w, output logic [31:0] d, output logic e);
        w = s == 0 ? b1.oWait : b4.oWait;
        d = s == 0 ? b1.oData : b4.oData;
        e = s == 0 ? b1.oErr : b4.oErr;
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic do_write(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input string name);
        logic w, e;
        logic [31:0] q;
        drive(s, 1'b0, 1'b1, a, d, be);
        @(negedge clk);
        get(s, w, q, e);
        tests++;
        if (w !== 1'b0) begin fails++; $display("FAIL %s write wait: got %b expected 0", name, w); end
        @(posedge clk); #1;
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_read(input int s, input logic [31:0] a, input logic [3:0] be, input int lat, input logic [31:0] exp, input string name);
        logic w, e;
        logic [31:0] q, want;
        int n = 0;
        sb.push_back(exp);
        drive(s, 1'b1, 1'b0, a, 32'h0, be);
        w = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            get(s, w, q, e);
            if (!w) break;
            n++;
            @(posedge clk); #1;
        end
        want = sb.pop_front();
        tests++;
        if (w) begin
            fails++; $display("FAIL %s timeout: oWait still 1 after %0d cycles", name, n);
        end else begin
            if (n != lat) begin fails++; $display("FAIL %s wait cycles: got %0d expected %0d", name, n, lat); end
            tests++;
            if (q !== want) begin fails++; $display("FAIL %s data: got %h expected %h", name, q, want); end
            @(posedge clk); #1;
        end
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset;
        logic w, e;
        logic [31:0] q;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hf);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hf);
        @(posedge clk); #1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            get(s, w, q, e);
            tests += 3;
            if (w !== 1'b0) begin fails++; $display("FAIL reset wait[%0d]: got %b expected 0", s, w); end
            if (q !== 32'h0) begin fails++; $display("FAIL reset data[%0d]: got %h expected 0", s, q); end
            if (e !== 1'b0) begin fails++; $display("FAIL reset err[%0d]: got %b expected 0", s, e); end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b1;
    endtask

    task automatic test_word_rw;
        do_write(0, 32'h40, 32'hdeadbeef, 4'hf, "wr1");
        do_read(0, 32'h40, 4'hf, 1, 32'hdeadbeef, "rd1");
        do_write(1, 32'h40, 32'h0badf00d, 4'hf, "wr4");
        do_read(1, 32'h40, 4'hf, 4, 32'h0badf00d, "rd4");
    endtask

    task automatic test_byte_lanes;
        do_write(0, 32'h40, 32'h11223344, 4'hf, "lanes_base");
        do_write(0, 32'h41, 32'h000000aa, 4'h1, "lanes_byte");
        do_write(0, 32'h42, 32'h0000bbcc, 4'h3, "lanes_half");
        do_read(0, 32'h40, 4'hf, 1, 32'hbbccaa44, "lanes_word");
        do_read(0, 32'h41, 4'h1, 1, 32'h000000aa, "lanes_rdbyte");
        do_read(0, 32'h42, 4'h3, 1, 32'h0000bbcc, "lanes_rdhalf");
    endtask

    task automatic test_lat4_squash;
        logic w, e;
        logic [31:0] q;
        do_write(1, 32'h80, 32'h12345678, 4'hf, "sq_wr");
        drive(1, 1'b1, 1'b0, 32'h80, 32'h0, 4'hf);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            get(1, w, q, e);
            tests++;
            if (w !== (c < 4)) begin fails++; $display("FAIL squash wait c%0d: got %b expected %b", c, w, c < 4); end
            @(posedge clk); #1;
            if (c == 1) drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        do_read(1, 32'h80, 4'hf, 4, 32'h12345678, "sq_next");
    endtask

    task automatic test_rw_collide;
        logic w, e;
        logic [31:0] q;
        for (int s = 0; s < 2; s++) begin
            drive(s, 1'b1, 1'b1, 32'h84, 32'ha5a55a5a + s, 4'hf);
            @(negedge clk);
            get(s, w, q, e);
            tests++;
            if (w !== 1'b0) begin fails++; $display("FAIL collide wait[%0d]: got %b expected 0", s, w); end
            @(posedge clk); #1;
            do_read(s, 32'h84, 4'hf, s == 0 ? 1 : 4, 32'ha5a55a5a + s, "collide_rd");
        end
    endtask

    task automatic test_reset_midread;
        logic w, e;
        logic [31:0] q;
        do_write(1, 32'h88, 32'hcafebabe, 4'hf, "rst_wr");
        drive(1, 1'b1, 1'b0, 32'h88, 32'h0, 4'hf);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        get(1, w, q, e);
        tests += 2;
        if (w !== 1'b0) begin fails++; $display("FAIL midrst wait: got %b expected 0", w); end
        if (q !== 32'h0) begin fails++; $display("FAIL midrst data: got %h expected 0", q); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_read(1, 32'h88, 4'hf, 4, 32'hcafebabe, "midrst_rd");
    endtask

    task automatic test_misalign;
        logic w, e;
        logic [31:0] q;
        do_write(0, 32'h50, 32'h55667788, 4'hf, "mis_base");
        @(negedge clk);
        get(0, w, q, e);
        tests++;
        if (e !== 1'b0) begin fails++; $display("FAIL mis err_before: got %b expected 0", e); end
        @(posedge clk); #1;
        do_write(0, 32'h52, 32'hcafef00d, 4'hf, "mis_wr");
        @(negedge clk);
        get(0, w, q, e);
        tests++;
        if (e !== CHK) begin fails++; $display("FAIL mis err_set: got %b expected %b", e, CHK); end
        @(posedge clk); #1;
        do_read(0, 32'h50, 4'hf, 1, CHK ? 32'h55667788 : 32'hf00d7788, "mis_mem");
        do_read(0, 32'h52, 4'hf, 1, CHK ? 32'h0 : 32'h0000f00d, "mis_rd");
        @(negedge clk);
        get(0, w, q, e);
        tests++;
        if (e !== CHK) begin fails++; $display("FAIL mis err_sticky: got %b expected %b", e, CHK); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_word_rw;
        test_byte_lanes;
        test_lat4_squash;
        test_rw_collide;
        test_reset_midread;
        test_misalign;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
